// File: rtl/ecc_ctrl_pkg.sv
// Shared ECC control types: point-op selectors, sequencer states
// and the default scalar width (also used by key_shift).
package ecc_ctrl_pkg;

  localparam int KEY_BITS_DFLT = 32;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_ADD,
    S_WAIT_ADD,
    S_DBL,
    S_WAIT_DBL,
    S_NEXT,
    S_WAIT_KEY,
    S_DONE
  } state_t;

endpackage

// File: rtl/scalar_op_issuer.sv
// Point-op launcher: registers start/sel/dummy toward the point unit
// and turns the unit's done pulse into a completion strobe.
module scalar_op_issuer
  import ecc_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic issue_i,
  input  logic sel_i,
  input  logic dummy_i,
  input  logic op_done_i,
  output logic op_start_o,
  output logic op_sel_o,
  output logic op_dummy_o,
  output logic cmpl_o
);

  logic start_q;
  logic sel_q;
  logic dummy_q;
  logic pend_q;

  // done in the launch cycle, or with nothing in flight, is dropped
  assign cmpl_o = pend_q & ~start_q & op_done_i;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_q <= 1'b0;
      sel_q   <= OP_DBL;
      dummy_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      start_q <= issue_i;
      if (issue_i) begin
        sel_q   <= sel_i;
        dummy_q <= dummy_i;
        pend_q  <= 1'b1;
      end else if (cmpl_o) begin
        pend_q  <= 1'b0;
      end
    end
  end

  assign op_start_o = start_q;
  assign op_sel_o   = sel_q;
  assign op_dummy_o = dummy_q;

endmodule

// File: rtl/scalar_mult_ctrl.sv
// LSB-first double-and-add sequencer for ECC scalar multiplication.
// SCALAR_MULT_CONST_TIME_EN: run a dummy ADD on zero key bits.
module scalar_mult_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int KEY_BITS = KEY_BITS_DFLT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_k_bit,
  input  logic i_key_ack,
  output logic o_key_clr,
  output logic o_key_next,
  output logic o_op_start,
  output logic o_op_sel,
  output logic o_op_dummy,
  input  logic i_op_done,
  output logic o_busy,
  output logic o_done
);

  localparam int CW = $clog2(KEY_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(KEY_BITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_q, clr_d;
  logic          next_q, next_d;
  logic          done_q, done_d;
  logic          busy_q;
  logic          issue, sel, dummy, cmpl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    next_d  = 1'b0;
    done_d  = 1'b0;
    issue   = 1'b0;
    sel     = OP_DBL;
    dummy   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CLR;
          cnt_d   = '0;
          clr_d   = 1'b1;
        end
      end
      S_CLR: state_d = S_FETCH;
      S_FETCH: begin
        issue = 1'b1;
`ifdef SCALAR_MULT_CONST_TIME_EN
        state_d = S_ADD;
        sel     = OP_ADD;
        dummy   = ~i_k_bit;
`else
        state_d = i_k_bit ? S_ADD : S_DBL;
        sel     = i_k_bit ? OP_ADD : OP_DBL;
`endif
      end
      S_ADD: state_d = S_WAIT_ADD;
      S_WAIT_ADD: begin
        if (cmpl) begin
          state_d = S_DBL;
          issue   = 1'b1;
        end
      end
      S_DBL: state_d = S_WAIT_DBL;
      S_WAIT_DBL: begin
        if (cmpl) begin
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_NEXT;
            next_d  = 1'b1;
          end
        end
      end
      S_NEXT: begin
        state_d = S_WAIT_KEY;
        cnt_d   = cnt_q + CW'(1);
      end
      S_WAIT_KEY: if (i_key_ack) state_d = S_FETCH;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      next_q  <= next_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  scalar_op_issuer u_issuer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .issue_i    (issue),
    .sel_i      (sel),
    .dummy_i    (dummy),
    .op_done_i  (i_op_done),
    .op_start_o (o_op_start),
    .op_sel_o   (o_op_sel),
    .op_dummy_o (o_op_dummy),
    .cmpl_o     (cmpl)
  );

  assign o_key_clr  = clr_q;
  assign o_key_next = next_q;
  assign o_done     = done_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Scoreboard bench for scalar_mult_ctrl with point-unit and
// key-shifter responders.
module tb_scalar_mult_ctrl;

  localparam int KB = 32;
`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_start = 1'b0;
  logic i_k_bit;
  logic i_key_ack = 1'b0;
  logic o_key_clr, o_key_next;
  logic o_op_start, o_op_sel, o_op_dummy;
  logic i_op_done;
  logic o_busy, o_done;

  logic pu_done = 1'b0;
  logic spur_done = 1'b0;
  assign i_op_done = pu_done | spur_done;

  logic [KB-1:0] key_q = '0;
  int idx = 0;
  assign i_k_bit = key_q[idx[4:0]];

  int lat = 3;
  int dly = 1;
  bit spur_en = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int nxt_cnt, clr_cnt, done_cnt, add_cnt;
  logic [1:0] q[$];

  always #5 i_clk = ~i_clk;

  scalar_mult_ctrl #(.KEY_BITS(KB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_k_bit    (i_k_bit),
    .i_key_ack  (i_key_ack),
    .o_key_clr  (o_key_clr),
    .o_key_next (o_key_next),
    .o_op_start (o_op_start),
    .o_op_sel   (o_op_sel),
    .o_op_dummy (o_op_dummy),
    .i_op_done  (i_op_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // point unit: done pulse lat cycles after o_op_start
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clk);
      pu_done = 1'b0;
      if (i_rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) pu_done = 1'b1;
        end
        if (o_op_start) cnt = lat;
      end
    end
  end

  // key shifter: ack dly cycles after o_key_next
  initial begin
    int kc;
    bit arm;
    kc = 0;
    arm = 1'b0;
    forever begin
      @(negedge i_clk);
      spur_done = 1'b0;
      i_key_ack = 1'b0;
      if (i_rst) begin
        kc = 0;
        arm = 1'b0;
      end else begin
        if (arm) begin
          spur_done = 1'b1;
          arm = 1'b0;
        end
        if (kc > 0) begin
          kc--;
          if (kc == 0) begin
            i_key_ack = 1'b1;
            idx++;
          end
        end
        if (o_key_clr) idx = 0;
        if (o_key_next) begin
          kc = dly;
          arm = spur_en;
        end
      end
    end
  end

  // monitor: pop scoreboard on each op launch
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge i_clk);
      if (o_key_next) nxt_cnt++;
      if (o_key_clr) clr_cnt++;
      if (o_done) done_cnt++;
      if (o_op_start) begin
        if (o_op_sel) add_cnt++;
        e = (q.size() > 0) ? q.pop_front() : 2'b01;
        chk("op", {o_op_sel, o_op_dummy}, e);
      end
    end
  end

  function automatic int exp_cycles(input logic [KB-1:0] k,
                                    input int l, input int d);
    int c;
    int a;
    c = 2;
    for (int i = 0; i < KB; i++) begin
      a = (CT || k[i]) ? 1 : 0;
      c += 1 + a * (1 + l) + 1 + l;
      if (i < KB - 1) c += 1 + d;
    end
    return c;
  endfunction

  task automatic push_exp(input logic [KB-1:0] k);
    for (int i = 0; i < KB; i++) begin
      if (CT) q.push_back({1'b1, ~k[i]});
      else if (k[i]) q.push_back(2'b10);
      q.push_back(2'b00);
    end
  endtask

  task automatic run(input logic [KB-1:0] k, input int l,
                     input int d, input bit spur, input bit mid);
    int n;
    int adds;
    adds = 0;
    for (int i = 0; i < KB; i++) adds += (CT || k[i]) ? 1 : 0;
    @(negedge i_clk);
    key_q = k;
    lat = l;
    dly = d;
    spur_en = spur;
    nxt_cnt = 0;
    clr_cnt = 0;
    done_cnt = 0;
    add_cnt = 0;
    push_exp(k);
    i_start = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (n == 1) begin
        i_start = 1'b0;
        chk("clr_c1", o_key_clr, 1);
        chk("busy_c1", o_busy, 1);
      end
      if (n == 2) chk("op_c2", o_op_start, 0);
      if (n == 3) chk("op_c3", o_op_start, 1);
      if (mid && n == 20) i_start = 1'b1;
      if (mid && n == 22) i_start = 1'b0;
    end while (!o_done && n < 5000);
    chk("cycles", n, exp_cycles(k, l, d));
    @(negedge i_clk);
    chk("busy_fall", o_busy, 0);
    chk("done_cnt", done_cnt, 1);
    chk("clr_cnt", clr_cnt, 1);
    chk("next_cnt", nxt_cnt, KB - 1);
    chk("add_cnt", add_cnt, adds);
    chk("q_left", q.size(), 0);
    spur_en = 1'b0;
    q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_outs", {o_key_clr, o_key_next, o_op_start, o_op_sel,
                     o_op_dummy, o_busy, o_done}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("idle_busy", o_busy, 0);

    run(32'h0000_0005, 3, 1, 1'b0, 1'b0);
    run(32'h0000_000F, 3, 1, 1'b0, 1'b0);
    run(32'h0000_0000, 3, 1, 1'b0, 1'b0);
    run(32'hFFFF_FFFF, 1, 1, 1'b0, 1'b0);
    run(32'h3C96_1E2B, 2, 10, 1'b1, 1'b1);

    // abort during the first WAIT_ADD
    @(negedge i_clk);
    key_q = 32'h0000_0001;
    lat = 3;
    dly = 1;
    push_exp(key_q);
    done_cnt = 0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_op_start && o_op_sel) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("abort_add_seen", {o_op_start, o_op_sel}, 2'b11);
    @(negedge i_clk);
    chk("abort_pre", {o_busy, o_op_sel}, 2'b11);
    #1;
    i_rst = 1'b1;
    #1;
    chk("abort_outs", {o_key_clr, o_key_next, o_op_start, o_op_sel,
                       o_op_dummy, o_busy, o_done}, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    q.delete();
    repeat (10) @(negedge i_clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", o_busy, 0);

    run(32'hA5A5_5A5A, 3, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
# scalar_mult_ctrl

Sequencer for LSB-first double-and-add ECC scalar multiplication. It consumes the scalar one bit at a time from the key shifter, acting as the controlling end of the key-bit handshake. For each bit it issues point ADD and DOUBLE commands to the point-arithmetic unit. It sits between the top-level start/done interface, the key shifter and the point-op datapath.

## Interface
- KEY_BITS, 32: scalar width; number of bits processed per run.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_k_bit  in  1  current scalar bit from the key shifter; valid while not awaiting ack.
- i_key_ack  in  1  key shifter's one-cycle pulse: index advanced, new i_k_bit valid.
- o_key_clr  out  1  one-cycle pulse: key shifter resets its index to bit 0.
- o_key_next  out  1  one-cycle pulse: request advance to the next bit.
- o_op_start  out  1  one-cycle pulse: launch point operation.
- o_op_sel  out  1  0 = DOUBLE, 1 = ADD; held stable from o_op_start until i_op_done.
- o_op_dummy  out  1  ADD result must be discarded; only ever 1 with SCALAR_MULT_CONST_TIME_EN.
- i_op_done  in  1  point unit's one-cycle completion pulse.
- o_busy  out  1  high from the cycle after start acceptance through the o_done cycle.
- o_done  out  1  one-cycle pulse: run complete.

## Operation
- All outputs are registered. Reset value of every output is 0. The state is IDLE and bit_cnt is 0.
- States: IDLE, CLR, FETCH, ADD, WAIT_ADD, DBL, WAIT_DBL, NEXT, WAIT_KEY, DONE.
- IDLE: when i_start=1, go to CLR and set bit_cnt=0. Otherwise hold.
- CLR: assert o_key_clr for one cycle, then go to FETCH.
- FETCH: latch i_k_bit into kb.
  - kb=1: go to ADD.
  - kb=0: go to DBL.
- ADD: pulse o_op_start with o_op_sel=1, then go to WAIT_ADD.
- WAIT_ADD: wait for i_op_done, then go to DBL.
- DBL: pulse o_op_start with o_op_sel=0, then go to WAIT_DBL.
- WAIT_DBL: on i_op_done:
  - if bit_cnt == KEY_BITS-1, go to DONE;
  - else go to NEXT.
- NEXT: pulse o_key_next, increment bit_cnt, then go to WAIT_KEY.
- WAIT_KEY: on i_key_ack, go to FETCH.
- DONE: pulse o_done, then go to IDLE.
- bit_cnt width is $clog2(KEY_BITS)+1. It never wraps within a run.
- Exactly KEY_BITS-1 o_key_next pulses are issued per run; there is no advance after the last bit.
- Boundary conditions:
  - i_start while busy: ignored.
  - i_op_done or i_key_ack outside its wait state: ignored, and not remembered.
  - i_op_done in the same cycle as o_op_start: not accepted.
  - i_rst mid-run: asynchronous return to IDLE; every output is 0 immediately. No o_done for the aborted run.

## Timing
- Start sampled in cycle 0.
- o_key_clr and o_busy rise in cycle 1.
- Bit 0 is latched in cycle 2.
- First o_op_start occurs in cycle 3.
- Per-bit overhead excluding point-op and ack latency:
  - kb=1: 7 cycles (FETCH, ADD, WAIT_ADD≥1, DBL, WAIT_DBL≥1, NEXT, WAIT_KEY≥1).
  - kb=0: 5 cycles.
- o_done is asserted 1 cycle after the final i_op_done.
- o_busy falls in the cycle after o_done.
- No combinational path from any input to any output.

## Configuration
- SCALAR_MULT_CONST_TIME_EN:
  - Defined: when kb=0, the block still runs the ADD/WAIT_ADD path with o_op_sel=1 and o_op_dummy=1. Every bit costs ADD+DOUBLE, so op sequence and timing are independent of the key.
  - Undefined: bits with kb=0 skip ADD. o_op_dummy is tied to 0.

## Structure
- Shared package ecc_ctrl_pkg contains:
  - OP_DBL=1'b0 and OP_ADD=1'b1;
  - the state enum typedef;
  - the KEY_BITS default, shared with key_shift.
- One natural sub-module: scalar_op_issuer. It owns the o_op_start/o_op_sel/o_op_dummy/i_op_done handshake and reports an op-complete strobe to the main FSM.

## Test plan
- KEY_BITS=4, k=4'b0101, 3-cycle point unit -> op sequence ADD,DBL,DBL,ADD,DBL,DBL; 3 o_key_next pulses; 1 o_key_clr; single o_done.
- Same stimulus with SCALAR_MULT_CONST_TIME_EN -> ADD,DBL,ADD(dummy),DBL,ADD,DBL,ADD(dummy),DBL; o_op_dummy=1 only on bits 1 and 3; total cycles equal to the run with k=4'hF.
- k=0 and k=all-ones, KEY_BITS=32 -> exactly 32 DBLs; ADD count 0 and 32 respectively; 31 o_key_next pulses.
- i_start pulsed mid-run; spurious i_op_done while in WAIT_KEY -> no restart; sequence unchanged; no extra op issued.
- i_rst asserted during WAIT_ADD -> all outputs 0 same cycle; no o_done; next i_start runs a full correct sequence from bit 0.
- i_key_ack delayed 10 cycles -> FSM holds in WAIT_KEY; no o_op_start until the cycle after FETCH.
